// File: rtl/demux1t4_5_buf.sv
// demux1t4_5_buf: one valid/ready source fanned out to four valid/ready sinks.
// Each sink owns a one-entry holding register. A stalled sink therefore only
// back-pressures words addressed to it.
//
// Handshake (all ports): a word moves across an interface on a rising edge
// where valid and ready are both 1. in_ready depends only on in_sel and
// out_ready (never on in_valid). A producer holds its word stable while
// valid=1 and ready=0. Sink words stay stable while out_valid=1 and
// out_ready=0.
module demux1t4_5_buf #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [2:0]         occupancy,
    output logic [CNT_W-1:0]   xfer_cnt
);

    logic [3:0]       full_q, full_d;
    logic [WIDTH-1:0] data_q [4];
    logic [2:0]       occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       push, pop;
    logic             acc;

    // Accept when the addressed slot is empty or is being drained this cycle.
    always_comb begin
        in_ready = ~full_q[in_sel] | out_ready[in_sel];
        acc      = in_valid & in_ready;
    end

    // Per-channel push/pop, next fill state, popcount and transfer count.
    always_comb begin
        push  = '0;
        pop   = '0;
        full_d = '0;
        occ_d = '0;
        for (int i = 0; i < 4; i++) begin
            pop[i]    = full_q[i] & out_ready[i];
            push[i]   = acc & (in_sel == 2'(i));
            full_d[i] = push[i] | (full_q[i] & ~pop[i]);
            occ_d     = occ_d + {2'b00, full_d[i]};
        end
        cnt_d = acc ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    // State registers; reset clears every held word immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*WIDTH +: WIDTH] = data_q[i];
        end
        out_valid = full_q;
        occupancy = occ_q;
        xfer_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_demux1t4_5_buf.sv
// Directed bench for demux1t4_5_buf: inputs change 1 ns after the rising
// edge, registered outputs are sampled 1 ns after the edge.
module tb_demux1t4_5_buf;

    localparam int WIDTH = 5;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [2:0]         occupancy;
    logic [CNT_W-1:0]   xfer_cnt;

    int n_checks = 0;
    int n_errors = 0;

    demux1t4_5_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sel   = sel;
        in_data  = d;
    endtask

    function automatic logic [WIDTH-1:0] slice(input logic [4*WIDTH-1:0] bus, input int i);
        return bus[i*WIDTH +: WIDTH];
    endfunction

    initial begin
        rst       = 1'b1;
        out_ready = 4'b0000;
        drive(1'b0, 2'd0, 5'h00);
        #3;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1. idle after reset
        check("t1_out_valid", 32'(out_valid), 32'h0);
        check("t1_in_ready", 32'(in_ready), 32'h1);
        check("t1_occupancy", 32'(occupancy), 32'h0);
        check("t1_xfer_cnt", 32'(xfer_cnt), 32'h0);

        // 2. single word to channel 2, held until the sink takes it
        drive(1'b1, 2'd2, 5'h15);
        #1;
        check("t2_in_ready", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 5'h00);
        check("t2_out_valid", 32'(out_valid), 32'h4);
        check("t2_data2", 32'(out_data[14:10]), 32'h15);
        check("t2_occupancy", 32'(occupancy), 32'h1);
        check("t2_xfer_cnt", 32'(xfer_cnt), 32'h1);
        step();
        step();
        check("t2_hold_valid", 32'(out_valid), 32'h4);
        check("t2_hold_data2", 32'(out_data[14:10]), 32'h15);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        check("t2_drain_valid", 32'(out_valid), 32'h0);
        check("t2_drain_occ", 32'(occupancy), 32'h0);

        // 3. stalled channel 1 blocks only its own traffic
        drive(1'b1, 2'd1, 5'h0A);
        step();
        check("t3_fill1_valid", 32'(out_valid), 32'h2);
        drive(1'b1, 2'd1, 5'h1F);
        #1;
        check("t3_blocked_ready", 32'(in_ready), 32'h0);
        step();
        check("t3_blocked_valid", 32'(out_valid), 32'h2);
        check("t3_blocked_data1", 32'(slice(out_data, 1)), 32'h0A);
        check("t3_blocked_cnt", 32'(xfer_cnt), 32'h2);
        drive(1'b1, 2'd3, 5'h07);
        #1;
        check("t3_other_ready", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 5'h00);
        check("t3_out_valid", 32'(out_valid), 32'hA);
        check("t3_data3", 32'(slice(out_data, 3)), 32'h07);
        check("t3_data1", 32'(slice(out_data, 1)), 32'h0A);
        check("t3_occupancy", 32'(occupancy), 32'h2);
        check("t3_xfer_cnt", 32'(xfer_cnt), 32'h3);
        out_ready = 4'b1010;
        step();
        out_ready = 4'b0000;
        check("t3_drain_valid", 32'(out_valid), 32'h0);

        // 4. stream 01..08 through channel 0 with no bubbles
        out_ready = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 2'd0, 5'(k));
            #1;
            check("t4_in_ready", 32'(in_ready), 32'h1);
            step();
            check("t4_valid0", 32'(out_valid), 32'h1);
            check("t4_data0", 32'(slice(out_data, 0)), 32'(k));
        end
        drive(1'b0, 2'd0, 5'h00);
        check("t4_xfer_cnt", 32'(xfer_cnt), 32'd11);
        step();
        out_ready = 4'b0000;
        check("t4_empty", 32'(out_valid), 32'h0);

        // 5. fill all channels, then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 5'(5'h10 + i));
            step();
        end
        check("t5_full_valid", 32'(out_valid), 32'hF);
        check("t5_full_occ", 32'(occupancy), 32'h4);
        check("t5_full_cnt", 32'(xfer_cnt), 32'd15);
        check("t5_full_data", 32'(out_data), {12'h0, 5'h13, 5'h12, 5'h11, 5'h10});
        drive(1'b1, 2'd0, 5'h1C);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'h0);
        check("t5_rst_occ", 32'(occupancy), 32'h0);
        check("t5_rst_cnt", 32'(xfer_cnt), 32'h0);
        check("t5_rst_data", 32'(out_data), 32'h0);
        step();
        rst = 1'b0;
        drive(1'b0, 2'd0, 5'h00);
        out_ready = 4'b1111;
        step();
        step();
        check("t5_post_valid", 32'(out_valid), 32'h0);
        check("t5_post_data", 32'(out_data), 32'h0);
        check("t5_post_cnt", 32'(xfer_cnt), 32'h0);

        // 6. 256 accepted transfers wrap the counter to 0
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, 2'(k % 4), 5'(k));
            step();
            if (k == 0) begin
                check("t6_first_valid", 32'(out_valid), 32'h1);
            end
            if (k == 254) begin
                check("t6_cnt_255", 32'(xfer_cnt), 32'd255);
            end
        end
        drive(1'b0, 2'd0, 5'h00);
        check("t6_cnt_wrap", 32'(xfer_cnt), 32'h0);
        check("t6_last_valid", 32'(out_valid), 32'h8);
        check("t6_last_data3", 32'(slice(out_data, 3)), 32'h1F);
        step();
        check("t6_drained", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
